// File: rtl/tone_band_detect_if.sv
// Tone-detector signal bundle: comparator input, per-band flags and window results.
// The slave modport is the detector side; the master modport is the driving/observing side.
interface tone_band_detect_if #(
  parameter int CNT_W = 16
);
  logic             sig;
  logic             pb1;
  logic             pb2;
  logic             pb3;
  logic             pb4;
  logic             win_done;
  logic [CNT_W-1:0] edge_count;

  modport master (output sig, input pb1, pb2, pb3, pb4, win_done, edge_count);
  modport slave  (input sig, output pb1, pb2, pb3, pb4, win_done, edge_count);
endinterface

// File: rtl/tone_band_detect.sv
// Counts rising edges of the synchronised comparator input per gate window, classifies the
// count into one of four bands and raises a persistent per-band flag. Optional TONE_GLITCH_FILTER_EN.
module tone_band_detect #(
  parameter int GATE_CYCLES = 500_000,
  parameter int CNT_W       = 16,
  parameter int B1_LO       = 8,
  parameter int B1_HI       = 12,
  parameter int B2_LO       = 18,
  parameter int B2_HI       = 22,
  parameter int B3_LO       = 28,
  parameter int B3_HI       = 32,
  parameter int B4_LO       = 38,
  parameter int B4_HI       = 42,
  parameter int PERSIST     = 2
) (
  input  logic                clk,
  input  logic                rst,
  tone_band_detect_if.slave   bus,
  output logic [1:0]          state_dbg
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

  localparam int WW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int PW = (PERSIST > 1) ? $clog2(PERSIST + 1) : 1;
  localparam logic [WW-1:0] WIN_LAST  = WW'(GATE_CYCLES - 1);
  localparam logic [PW-1:0] PERSIST_V = PW'(PERSIST);

  logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic             level, rise, close;
  logic [WW-1:0]    win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, sum, edge_count_q, edge_count_d;
  logic             win_done_q, win_done_d;
  state_t           state_q, state_d;
  logic [1:0]       cand_q, cand_d, m_band;
  logic             m_hit;
  logic [PW-1:0]    hits_q, hits_d, misses_q, misses_d;
  logic [3:0]       pb_q, pb_d;
`ifdef TONE_GLITCH_FILTER_EN
  logic             hist1_q, hist1_d, hist2_q, hist2_d, filt_q, filt_d;
`endif

  function automatic logic in_band(input logic [CNT_W-1:0] c, input int lo, input int hi);
    return (c >= CNT_W'(lo)) && (c <= CNT_W'(hi));
  endfunction

  always_comb begin
    sync1_d = bus.sig;
    sync2_d = sync1_q;
`ifdef TONE_GLITCH_FILTER_EN
    // Filtered level follows the synchroniser only after three identical samples.
    hist1_d = sync2_q;
    hist2_d = hist1_q;
    filt_d  = filt_q;
    if ((sync2_q == hist1_q) && (hist1_q == hist2_q)) filt_d = sync2_q;
    level   = filt_q;
`else
    level   = sync2_q;
`endif
    prev_d = level;
    rise   = level & ~prev_q;
    close  = (win_q == WIN_LAST);
    win_d  = close ? '0 : win_q + 1'b1;
    sum    = (rise && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    cnt_d  = close ? '0 : sum;
    edge_count_d = close ? sum : edge_count_q;
    win_done_d   = close;

    // Lowest band index wins when bands overlap.
    m_hit  = 1'b1;
    m_band = 2'd0;
    if      (in_band(sum, B1_LO, B1_HI)) m_band = 2'd0;
    else if (in_band(sum, B2_LO, B2_HI)) m_band = 2'd1;
    else if (in_band(sum, B3_LO, B3_HI)) m_band = 2'd2;
    else if (in_band(sum, B4_LO, B4_HI)) m_band = 2'd3;
    else                                 m_hit  = 1'b0;

    state_d  = state_q;
    cand_d   = cand_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    if (close) begin
      case (state_q)
        IDLE: if (m_hit) begin
          cand_d   = m_band;
          hits_d   = PW'(1);
          misses_d = '0;
          state_d  = (PERSIST == 1) ? LOCKED : ACQUIRE;
        end
        ACQUIRE: begin
          if (!m_hit) begin
            state_d = IDLE;
          end else if (m_band == cand_q) begin
            hits_d = hits_q + 1'b1;
            if (hits_q + 1'b1 >= PERSIST_V) begin
              state_d  = LOCKED;
              misses_d = '0;
            end
          end else begin
            cand_d = m_band;
            hits_d = PW'(1);
          end
        end
        LOCKED: begin
          if (m_hit && (m_band == cand_q)) begin
            misses_d = '0;
          end else begin
            misses_d = misses_q + 1'b1;
            if (misses_q + 1'b1 >= PERSIST_V) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pb_d = '0;
    if (state_d == LOCKED) pb_d[cand_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      win_q        <= '0;
      cnt_q        <= '0;
      edge_count_q <= '0;
      win_done_q   <= 1'b0;
      state_q      <= IDLE;
      cand_q       <= 2'd0;
      hits_q       <= '0;
      misses_q     <= '0;
      pb_q         <= '0;
`ifdef TONE_GLITCH_FILTER_EN
      hist1_q      <= 1'b0;
      hist2_q      <= 1'b0;
      filt_q       <= 1'b0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      prev_q       <= prev_d;
      win_q        <= win_d;
      cnt_q        <= cnt_d;
      edge_count_q <= edge_count_d;
      win_done_q   <= win_done_d;
      state_q      <= state_d;
      cand_q       <= cand_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      pb_q         <= pb_d;
`ifdef TONE_GLITCH_FILTER_EN
      hist1_q      <= hist1_d;
      hist2_q      <= hist2_d;
      filt_q       <= filt_d;
`endif
    end
  end

  assign bus.pb1        = pb_q[0];
  assign bus.pb2        = pb_q[1];
  assign bus.pb3        = pb_q[2];
  assign bus.pb4        = pb_q[3];
  assign bus.win_done   = win_done_q;
  assign bus.edge_count = edge_count_q;
  assign state_dbg      = state_q;
endmodule

// File: tb/tb_tone_band_detect.sv
// Self-checking bench for tone_band_detect with a short gate window and narrow counter.
// Reference model tracks windows since the last lock/unlock as a queue of band classes.
module tb_tone_band_detect;
  localparam int GATE = 600;
  localparam int CW   = 6;
  localparam int P    = 2;
  localparam int SAT  = (1 << CW) - 1;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  int         n_cmp;
  int         n_err;
  int         model_lock;
  int         hist[$];
  int         band_lo[4];
  int         band_hi[4];

  tone_band_detect_if #(.CNT_W(CW)) bus ();

  tone_band_detect #(
    .GATE_CYCLES(GATE), .CNT_W(CW), .PERSIST(P)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classify(input int c);
    for (int b = 0; b < 4; b++)
      if (c >= band_lo[b] && c <= band_hi[b]) return b + 1;
    return 0;
  endfunction

  // Lock when the last P classes since the last transition are one band;
  // release when the last P classes all differ from the locked band.
  task automatic model_update(input int cls);
    bit all_same;
    bit all_other;
    hist.push_back(cls);
    if (hist.size() < P) return;
    all_same  = 1'b1;
    all_other = 1'b1;
    for (int i = hist.size() - P; i < hist.size(); i++) begin
      if (hist[i] != cls || cls == 0) all_same = 1'b0;
      if (hist[i] == model_lock) all_other = 1'b0;
    end
    if (model_lock == 0 && all_same) begin
      model_lock = cls;
      hist.delete();
    end else if (model_lock != 0 && all_other) begin
      model_lock = 0;
      hist.delete();
    end
  endtask

  function automatic logic [3:0] exp_flags();
    logic [3:0] f;
    f = 4'b0;
    if (model_lock != 0) f[model_lock-1] = 1'b1;
    return f;
  endfunction

  // Starts at the negedge of a window's first cycle; ends at the negedge after its close.
  task automatic run_window(input string name, input int n, input bit glitch);
    int         per, start, n_eff, exp_cnt;
    logic [3:0] flags_before, flags_now;
    per   = glitch ? 16 : 8;
    start = $urandom_range(4, 8);
    flags_before = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
    for (int t = 0; t < GATE; t++) begin
      int k, ph;
      bus.sig = 1'b0;
      if (t >= start) begin
        k  = (t - start) / per;
        ph = (t - start) % per;
        if (k < n && (ph < 4 || (glitch && ph == 8))) bus.sig = 1'b1;
      end
      if (t == GATE / 2) begin
        flags_now = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
        n_cmp++;
        if (bus.win_done !== 1'b0 || flags_now !== flags_before) begin
          n_err++;
          $display("FAIL %s mid_window: win_done=%b flags=%b, required win_done=0 flags=%b",
                   name, bus.win_done, flags_now, flags_before);
        end
      end
      @(posedge clk);
      if (t < GATE - 1) @(negedge clk);
    end
    #1;
`ifdef TONE_GLITCH_FILTER_EN
    n_eff = n;
`else
    n_eff = glitch ? 2 * n : n;
`endif
    exp_cnt = (n_eff > SAT) ? SAT : n_eff;
    model_update(classify(exp_cnt));
    flags_now = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
    n_cmp++;
    if (bus.win_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s win_done: got %b, required 1", name, bus.win_done);
    end
    n_cmp++;
    if (bus.edge_count !== CW'(exp_cnt)) begin
      n_err++;
      $display("FAIL %s edge_count: got %0d, required %0d", name, bus.edge_count, exp_cnt);
    end
    n_cmp++;
    if (flags_now !== exp_flags()) begin
      n_err++;
      $display("FAIL %s flags: got %b, required %b (n=%0d)", name, flags_now, exp_flags(), n);
    end
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    logic [3:0] f;
    f = {bus.pb4, bus.pb3, bus.pb2, bus.pb1};
    n_cmp++;
    if (f !== 4'b0 || bus.win_done !== 1'b0 || bus.edge_count !== '0) begin
      n_err++;
      $display("FAIL %s: flags=%b win_done=%b edge_count=%0d, required all 0",
               name, f, bus.win_done, bus.edge_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sig = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    model_lock = 0;
    hist.delete();
    rst = 1'b0;
  endtask

  task automatic test_1khz();
    for (int i = 0; i < 3; i++) run_window("tone_1k", 10, 1'b0);
  endtask

  task automatic test_release_3k();
    int seq[6];
    seq = '{0, 0, 30, 30, 0, 0};
    for (int i = 0; i < 6; i++) run_window("release_3k", seq[i], 1'b0);
  endtask

  task automatic test_band_switch();
    int seq[3];
    seq = '{20, 40, 40};
    for (int i = 0; i < 3; i++) run_window("switch_2k_4k", seq[i], 1'b0);
  endtask

  task automatic test_boundaries();
    int seq[4];
    seq = '{8, 7, 12, 13};
    for (int i = 0; i < 4; i++) run_window("boundary", seq[i], 1'b0);
  endtask

  task automatic test_random();
    int centre[4];
    int n, b;
    centre = '{10, 20, 30, 40};
    b = 0;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) b = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) n = $urandom_range(0, 70);
      else n = centre[b] + $urandom_range(0, 4) - 2;
      run_window("random", n, 1'b0);
    end
  endtask

  task automatic test_saturation();
    run_window("saturation", 70, 1'b0);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 3; i++) run_window("glitch", 10, 1'b1);
  endtask

  task automatic test_async_reset();
    run_window("pre_reset", 10, 1'b0);
    run_window("pre_reset", 10, 1'b0);
    for (int t = 0; t < 200; t++) begin
      bus.sig = ((t % 8) < 4);
      @(negedge clk);
    end
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    bus.sig = 1'b0;
    model_lock = 0;
    hist.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_window("post_reset", 10, 1'b0);
    run_window("post_reset", 10, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    band_lo = '{8, 18, 28, 38};
    band_hi = '{12, 22, 32, 42};
    test_reset();
    test_1khz();
    test_release_3k();
    test_band_switch();
    test_boundaries();
    test_random();
    test_saturation();
    test_glitch();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
